// File: rtl/timer_apb_slave_pkg.sv
// timer_pkg: register map, bit positions and shared types for the APB timer
package timer_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] ADDR_TDR  = 8'h00;
    localparam logic [ADDR_W-1:0] ADDR_TCR  = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_TSR  = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_TCNT = 8'h03;
    localparam int TCR_LOAD = 7;
    localparam int TCR_DOWN = 5;
    localparam int TCR_EN   = 4;
    localparam int TSR_OVF  = 0;
    localparam int TSR_UDF  = 1;
    localparam logic [DATA_W-1:0] TCR_MASK = 8'hb3;
    typedef enum logic [1:0] {CKS_2, CKS_4, CKS_8, CKS_16} cks_e;
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} apb_state_e;
    function automatic logic [3:0] cks_limit(cks_e c);
        return 4'((2 << c) - 1);
    endfunction
endpackage

// File: rtl/timer_apb_slave_if.sv
// timer_apb_slave_if: APB bus bundle between the CPU master and the timer
interface timer_apb_slave_if;
    import timer_pkg::*;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/timer_apb_slave_prescaler.sv
// timer_prescaler: clock divider producing a one-cycle tick every 2/4/8/16 enabled cycles
module timer_prescaler
    import timer_pkg::*;
(
    input  logic pclk,
    input  logic preset,
    input  logic en,
    input  cks_e cks,
    output logic tick
);
    logic [3:0] div;
    assign tick = en && div == cks_limit(cks);
    // divider cleared while disabled, wraps on the compare without resetting on a CKS change
    always_ff @(posedge pclk) div <= (preset || !en || tick) ? '0 : div + 4'd1;
endmodule

// File: rtl/timer_apb_slave.sv
// timer_apb_slave: APB completer holding the timer register set and up/down counter
module timer_apb_slave
    import timer_pkg::*;
(
    input  logic             pclk,
    input  logic             preset,
    timer_apb_slave_if.slave bus,
    output logic             irq_ovf,
    output logic             irq_udf
);
    apb_state_e        state;
    logic [DATA_W-1:0] tdr;
    logic [DATA_W-1:0] tcr;
    logic [DATA_W-1:0] tcnt;
    logic [1:0]        tsr;
    logic [DATA_W-1:0] rd_data;
    logic              tick;
    logic              load;
    logic              down;
    logic              wr;
    logic              wr_tsr;
    logic              set_ovf;
    logic              set_udf;
    logic              mapped;

    assign load    = tcr[TCR_LOAD];
    assign down    = tcr[TCR_DOWN];
    assign wr      = state == DONE && bus.psel && bus.pwrite;
    assign wr_tsr  = wr && bus.paddr == ADDR_TSR;
    assign mapped  = bus.paddr <= ADDR_TCNT;
    assign set_ovf = !load && tick && !down && tcnt == 8'hff;
    assign set_udf = !load && tick && down && tcnt == 8'h00;
    assign irq_ovf = tsr[TSR_OVF];
    assign irq_udf = tsr[TSR_UDF];
    assign rd_data = bus.paddr == ADDR_TDR  ? tdr :
                     bus.paddr == ADDR_TCR  ? tcr :
                     bus.paddr == ADDR_TSR  ? {6'b0, tsr} :
                     bus.paddr == ADDR_TCNT ? tcnt : '0;

    timer_prescaler u_prescaler (
        .pclk   (pclk),
        .preset (preset),
        .en     (tcr[TCR_EN] && !load),
        .cks    (cks_e'(tcr[1:0])),
        .tick   (tick)
    );

    // bus FSM; read data and error are captured in WAIT and presented with pready in DONE
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
        end else if (!bus.psel) begin
            state       <= IDLE;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE:  state <= bus.penable ? IDLE : SETUP;
                SETUP: state <= bus.penable ? WAIT : SETUP;
                WAIT: begin
                    state       <= DONE;
                    bus.pready  <= 1'b1;
                    bus.prdata  <= rd_data;
                    bus.pslverr <= !mapped;
                end
                default: begin
                    state       <= bus.penable ? IDLE : SETUP;
                    bus.pready  <= 1'b0;
                    bus.pslverr <= 1'b0;
                end
            endcase
        end
    end

    // software writes to TDR/TCR and the counter load/step
    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr  <= '0;
            tcr  <= '0;
            tcnt <= '0;
        end else begin
            if (wr && bus.paddr == ADDR_TDR) tdr <= bus.pwdata;
            if (wr && bus.paddr == ADDR_TCR) tcr <= bus.pwdata & TCR_MASK;
            if (load) tcnt <= tdr;
            else if (tick) tcnt <= down ? tcnt - 8'd1 : tcnt + 8'd1;
        end
    end

    // status flags: write-0-to-clear, a same-cycle hardware set wins
    always_ff @(posedge pclk) begin
        if (preset) tsr <= '0;
        else begin
            tsr[TSR_OVF] <= set_ovf || (tsr[TSR_OVF] && !(wr_tsr && !bus.pwdata[TSR_OVF]));
            tsr[TSR_UDF] <= set_udf || (tsr[TSR_UDF] && !(wr_tsr && !bus.pwdata[TSR_UDF]));
        end
    end
endmodule
